// File: rtl/vend_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
// Module  : vend_ctrl_multi_if
// Brief   : Button, selection, coin and change-dispense bus of vend_ctrl_multi.
// Revision: 1.0 - initial release
// ============================================================================
interface vend_ctrl_multi_if #(
  parameter int QTY_W = 2,
  parameter int AMT_W = 10
);
  logic             btn_start;
  logic             btn_add;
  logic             btn_confirm;
  logic             btn_cancel;
  logic [3:0]       sel_code;
  logic [QTY_W-1:0] sel_qty;
  logic [4:0]       coin_in;
  logic             chg_ready;
  logic             chg_valid;
  logic [4:0]       chg_denom;
  logic [AMT_W-1:0] due_o;
  logic [AMT_W-1:0] paid_o;
  logic [3:0]       lines_o;
  logic [2:0]       state_o;
  logic             vend_pulse;
  logic             coin_reject;
  logic             line_reject;

  modport master (
    output btn_start, btn_add, btn_confirm, btn_cancel, sel_code, sel_qty,
           coin_in, chg_ready,
    input  chg_valid, chg_denom, due_o, paid_o, lines_o, state_o,
           vend_pulse, coin_reject, line_reject
  );

  modport slave (
    input  btn_start, btn_add, btn_confirm, btn_cancel, sel_code, sel_qty,
           coin_in, chg_ready,
    output chg_valid, chg_denom, due_o, paid_o, lines_o, state_o,
           vend_pulse, coin_reject, line_reject
  );
endinterface
`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module  : vend_ctrl_multi
// Brief   : Multi-line vending controller with coin payment and greedy change.
//           Optional PAYMENT inactivity timeout when VEND_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module vend_ctrl_multi #(
  parameter int MAX_ITEMS   = 4,
  parameter int QTY_W       = 2,
  parameter int AMT_W       = 10,
  parameter int TIMEOUT_CYC = 1000000
) (
  input wire              sys_clk,
  input wire              sys_rst_n,
  vend_ctrl_multi_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    PAYMENT = 3'd2,
    VEND    = 3'd3,
    CHANGE  = 3'd4
  } state_t;

  // Wide enough for any money register plus one line cost or one coin.
  localparam int                 c_sum_w   = AMT_W + QTY_W + 5;
  localparam logic [c_sum_w-1:0] c_amt_max = c_sum_w'({AMT_W{1'b1}});

  if (MAX_ITEMS < 2 || MAX_ITEMS > 8 || AMT_W < 6 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("vend_ctrl_multi: parameter out of range");
  end

  function automatic logic [3:0] price_of(input logic [3:0] code);
    case (code)
      4'd0:  price_of = 4'd3;   4'd1:  price_of = 4'd4;
      4'd2:  price_of = 4'd6;   4'd3:  price_of = 4'd3;
      4'd4:  price_of = 4'd10;  4'd5:  price_of = 4'd8;
      4'd6:  price_of = 4'd9;   4'd7:  price_of = 4'd7;
      4'd8:  price_of = 4'd4;   4'd9:  price_of = 4'd6;
      4'd10: price_of = 4'd15;  4'd11: price_of = 4'd8;
      4'd12: price_of = 4'd9;   4'd13: price_of = 4'd4;
      4'd14: price_of = 4'd5;   default: price_of = 4'd5;
    endcase
  endfunction

  function automatic logic [5:0] coin_val(input logic [4:0] coin);
    case (coin)
      5'b10000: coin_val = 6'd50;
      5'b01000: coin_val = 6'd20;
      5'b00100: coin_val = 6'd10;
      5'b00010: coin_val = 6'd5;
      5'b00001: coin_val = 6'd1;
      default:  coin_val = 6'd0;
    endcase
  endfunction

  function automatic logic [4:0] greedy(input logic [AMT_W-1:0] amt);
    if      (amt >= AMT_W'(50)) greedy = 5'b10000;
    else if (amt >= AMT_W'(20)) greedy = 5'b01000;
    else if (amt >= AMT_W'(10)) greedy = 5'b00100;
    else if (amt >= AMT_W'(5))  greedy = 5'b00010;
    else if (amt != '0)         greedy = 5'b00001;
    else                        greedy = 5'b00000;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [AMT_W-1:0]   r_due, w_due_nxt;
  logic [AMT_W-1:0]   r_paid, w_paid_nxt;
  logic [3:0]         r_lines, w_lines_nxt;
  logic               r_line_rej, w_line_rej;
  logic               r_coin_rej, w_coin_rej;
  logic [c_sum_w-1:0] w_line_cost, w_due_sum, w_paid_sum;
  logic               w_coin_ok;
  logic [4:0]         w_chg_denom;
  logic               w_timeout;

  assign w_line_cost = c_sum_w'(price_of(bus.sel_code)) * c_sum_w'(bus.sel_qty);
  assign w_due_sum   = c_sum_w'(r_due) + w_line_cost;
  assign w_paid_sum  = c_sum_w'(r_paid) + c_sum_w'(coin_val(bus.coin_in));
  assign w_coin_ok   = $onehot(bus.coin_in) && (w_paid_sum <= c_amt_max);
  // Derived from paid_o, which only moves on acceptance, so it holds stable.
  assign w_chg_denom = (r_state == CHANGE) ? greedy(r_paid) : 5'b00000;

`ifdef VEND_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);
  logic [c_tmo_w-1:0] r_tmo_cnt;

  assign w_timeout = (r_state == PAYMENT) && !w_coin_ok &&
                     (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_tmo_cnt <= '0;
    else if (r_state != PAYMENT || w_state_nxt != PAYMENT || w_coin_ok)
      r_tmo_cnt <= '0;
    else
      r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_due      <= '0;
      r_paid     <= '0;
      r_lines    <= '0;
      r_line_rej <= 1'b0;
      r_coin_rej <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_due      <= w_due_nxt;
      r_paid     <= w_paid_nxt;
      r_lines    <= w_lines_nxt;
      r_line_rej <= w_line_rej;
      r_coin_rej <= w_coin_rej;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_due_nxt   = r_due;
    w_paid_nxt  = r_paid;
    w_lines_nxt = r_lines;
    w_line_rej  = 1'b0;
    w_coin_rej  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.btn_start) w_state_nxt = SELECT;
      end
      SELECT: begin
        if (bus.btn_cancel) begin
          w_due_nxt   = '0;
          w_lines_nxt = '0;
          w_state_nxt = IDLE;
        end else if (bus.btn_confirm && r_lines != 4'd0) begin
          w_state_nxt = PAYMENT;
        end else if (bus.btn_add) begin
          if (bus.sel_qty == '0 || r_lines == 4'(MAX_ITEMS) || w_due_sum > c_amt_max) begin
            w_line_rej = 1'b1;
          end else begin
            w_due_nxt   = w_due_sum[AMT_W-1:0];
            w_lines_nxt = r_lines + 4'd1;
          end
        end
      end
      PAYMENT: begin
        if (bus.coin_in != 5'b00000) begin
          if (w_coin_ok) w_paid_nxt = w_paid_sum[AMT_W-1:0];
          else           w_coin_rej = 1'b1;
        end
        // Cancel (or timeout) wins; confirm sees the coin arriving this cycle.
        if (bus.btn_cancel || w_timeout) begin
          w_due_nxt   = '0;
          w_state_nxt = CHANGE;
        end else if (bus.btn_confirm && w_paid_nxt >= r_due) begin
          w_state_nxt = VEND;
        end
      end
      VEND: begin
        w_paid_nxt  = r_paid - r_due;
        w_due_nxt   = '0;
        w_state_nxt = CHANGE;
      end
      CHANGE: begin
        if (r_paid == '0) begin
          w_lines_nxt = '0;
          w_state_nxt = IDLE;
        end else if (bus.chg_ready) begin
          w_paid_nxt = r_paid - AMT_W'(coin_val(w_chg_denom));
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.state_o     = r_state;
  assign bus.due_o       = r_due;
  assign bus.paid_o      = r_paid;
  assign bus.lines_o     = r_lines;
  assign bus.vend_pulse  = (r_state == VEND);
  assign bus.line_reject = r_line_rej;
  assign bus.coin_reject = r_coin_rej;
  assign bus.chg_valid   = (w_chg_denom != 5'b00000);
  assign bus.chg_denom   = w_chg_denom;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_vend_ctrl_multi
// Brief   : Directed self-checking bench for vend_ctrl_multi (VEND_TIMEOUT_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vend_ctrl_multi;

`ifdef VEND_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1000000;
`endif

  localparam logic [4:0] C50 = 5'b10000, C20 = 5'b01000, C10 = 5'b00100,
                         C5  = 5'b00010, C1  = 5'b00001;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   vend_cnt  = 0;
  int   vend_base;

  vend_ctrl_multi_if #(.QTY_W(2), .AMT_W(10)) bus ();

  vend_ctrl_multi #(
    .MAX_ITEMS  (4),
    .QTY_W      (2),
    .AMT_W      (10),
    .TIMEOUT_CYC(TB_TMO)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk)
    if (bus.vend_pulse) vend_cnt <= vend_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] code;
    logic [1:0] qty;
    logic       rej;
    logic [9:0] due;
    logic [3:0] lines;
  } add_vec_t;

  add_vec_t   vec [6];
  logic [4:0] exp_chg [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // One-cycle pulse of the selected buttons and coin, then everything released.
  task automatic step(input logic st, input logic ad, input logic cf, input logic cn,
                      input logic [4:0] coin);
    bus.btn_start   = st;
    bus.btn_add     = ad;
    bus.btn_confirm = cf;
    bus.btn_cancel  = cn;
    bus.coin_in     = coin;
    cyc();
    bus.btn_start   = 1'b0;
    bus.btn_add     = 1'b0;
    bus.btn_confirm = 1'b0;
    bus.btn_cancel  = 1'b0;
    bus.coin_in     = 5'b00000;
  endtask

  task automatic order(input logic [3:0] code, input logic [1:0] qty);
    step(1, 0, 0, 0, 0);
    bus.sel_code = code;
    bus.sel_qty  = qty;
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    bus.chg_ready = 1'b1;
    n = 0;
    while (bus.state_o != 3'd0 && n < budget) begin
      cyc();
      n++;
    end
    check(name, 32'(bus.state_o), 0);
    check({name, "_paid"}, 32'(bus.paid_o), 0);
    bus.chg_ready = 1'b0;
  endtask

  initial begin
    vec[0] = '{4'd0,  2'd1, 1'b0, 10'd3,  4'd1};
    vec[1] = '{4'd4,  2'd3, 1'b0, 10'd33, 4'd2};
    vec[2] = '{4'd7,  2'd0, 1'b1, 10'd33, 4'd2};
    vec[3] = '{4'd15, 2'd2, 1'b0, 10'd43, 4'd3};
    vec[4] = '{4'd10, 2'd1, 1'b0, 10'd58, 4'd4};
    vec[5] = '{4'd1,  2'd1, 1'b1, 10'd58, 4'd4};
    exp_chg = '{C20, C20, C1, C1, C1};

    bus.btn_start = 0; bus.btn_add = 0; bus.btn_confirm = 0; bus.btn_cancel = 0;
    bus.sel_code = 0; bus.sel_qty = 0; bus.coin_in = 0; bus.chg_ready = 0;

    // Reset state
    repeat (3) cyc();
    check("rst_state", 32'(bus.state_o), 0);
    check("rst_due", 32'(bus.due_o), 0);
    check("rst_paid", 32'(bus.paid_o), 0);
    check("rst_lines", 32'(bus.lines_o), 0);
    check("rst_chg_valid", 32'(bus.chg_valid), 0);
    check("rst_vend", 32'(bus.vend_pulse), 0);
    sys_rst_n = 1'b1;
    cyc();

    // Coins ignored in IDLE; confirm with no lines ignored in SELECT
    step(0, 0, 0, 0, 5'b00011);
    check("idle_coin_rej", 32'(bus.coin_reject), 0);
    check("idle_paid", 32'(bus.paid_o), 0);
    step(1, 0, 0, 0, 0);
    check("start_state", 32'(bus.state_o), 1);
    step(0, 0, 1, 0, 0);
    check("confirm_empty", 32'(bus.state_o), 1);

    // Line table: prices, qty 0 and MAX_ITEMS rejections
    for (int i = 0; i < 6; i++) begin
      bus.sel_code = vec[i].code;
      bus.sel_qty  = vec[i].qty;
      step(0, 1, 0, 0, 0);
      check($sformatf("add%0d_rej", i), 32'(bus.line_reject), 32'(vec[i].rej));
      check($sformatf("add%0d_due", i), 32'(bus.due_o), 32'(vec[i].due));
      check($sformatf("add%0d_lines", i), 32'(bus.lines_o), 32'(vec[i].lines));
    end
    step(0, 0, 1, 0, 0);
    check("pay_state", 32'(bus.state_o), 2);
    step(0, 0, 0, 0, 5'b00011);
    check("multi_coin_rej", 32'(bus.coin_reject), 1);
    check("multi_coin_paid", 32'(bus.paid_o), 0);
    step(0, 0, 0, 0, C50);
    check("c50_paid", 32'(bus.paid_o), 50);
    check("c50_norej", 32'(bus.coin_reject), 0);
    step(0, 0, 1, 0, 0);
    check("early_confirm", 32'(bus.state_o), 2);
    step(0, 0, 0, 0, C5);
    step(0, 0, 0, 0, C1);
    step(0, 0, 0, 0, C1);
    vend_base = vend_cnt;
    step(0, 0, 1, 0, C1);
    check("samecyc_vend_state", 32'(bus.state_o), 3);
    check("samecyc_paid", 32'(bus.paid_o), 58);
    check("samecyc_vend_pulse", 32'(bus.vend_pulse), 1);
    cyc();
    check("exact_chg_state", 32'(bus.state_o), 4);
    check("exact_chg_valid", 32'(bus.chg_valid), 0);
    cyc();
    check("exact_idle", 32'(bus.state_o), 0);
    check("exact_lines", 32'(bus.lines_o), 0);
    check("exact_vend_cnt", 32'(vend_cnt - vend_base), 1);

    // Code 0x0A x2, coins 20+10, exact payment
    vend_base = vend_cnt;
    order(4'hA, 2'd2);
    check("o30_due", 32'(bus.due_o), 30);
    step(0, 0, 0, 0, C20);
    step(0, 0, 0, 0, C10);
    check("o30_paid", 32'(bus.paid_o), 30);
    step(0, 0, 1, 0, 0);
    cyc();
    check("o30_paid_after", 32'(bus.paid_o), 0);
    check("o30_due_after", 32'(bus.due_o), 0);
    check("o30_no_change", 32'(bus.chg_valid), 0);
    cyc();
    check("o30_idle", 32'(bus.state_o), 0);
    check("o30_vend_cnt", 32'(vend_cnt - vend_base), 1);

    // Due 7, pay 50, greedy change 43 with chg_ready held high
    order(4'd7, 2'd1);
    check("o7_due", 32'(bus.due_o), 7);
    step(0, 0, 0, 0, C50);
    bus.chg_ready = 1'b1;
    step(0, 0, 1, 0, 0);
    cyc();
    check("o7_change_amt", 32'(bus.paid_o), 43);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("o7_chg%0d_valid", i), 32'(bus.chg_valid), 1);
      check($sformatf("o7_chg%0d_denom", i), 32'(bus.chg_denom), 32'(exp_chg[i]));
      cyc();
    end
    check("o7_drained_valid", 32'(bus.chg_valid), 0);
    cyc();
    check("o7_idle", 32'(bus.state_o), 0);
    bus.chg_ready = 1'b0;

    // Due 10, coin 5, cancel: refund held stable while dispenser stalls
    vend_base = vend_cnt;
    order(4'd4, 2'd1);
    step(0, 0, 0, 0, C5);
    step(0, 0, 1, 1, 0);
    check("cancel_state", 32'(bus.state_o), 4);
    check("cancel_due", 32'(bus.due_o), 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_denom", i), 32'(bus.chg_denom), 32'(C5));
      check($sformatf("stall%0d_valid", i), 32'(bus.chg_valid), 1);
      cyc();
    end
    bus.chg_ready = 1'b1;
    cyc();
    check("refund_paid", 32'(bus.paid_o), 0);
    cyc();
    check("refund_idle", 32'(bus.state_o), 0);
    check("refund_no_vend", 32'(vend_cnt - vend_base), 0);
    bus.chg_ready = 1'b0;

    // Coin overflow above 1023 is rejected
    order(4'd0, 2'd1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, C50);
    check("ovf_paid_1000", 32'(bus.paid_o), 1000);
    step(0, 0, 0, 0, C50);
    check("ovf_rej", 32'(bus.coin_reject), 1);
    check("ovf_paid_hold", 32'(bus.paid_o), 1000);
    step(0, 0, 0, 0, C20);
    check("ovf_paid_1020", 32'(bus.paid_o), 1020);
    step(0, 0, 0, 1, 0);
    drain("ovf_drain", 40);

    // Asynchronous reset while a change coin is on offer
    order(4'd0, 2'd1);
    step(0, 0, 0, 0, C5);
    step(0, 0, 1, 0, 0);
    cyc();
    check("prerst_valid", 32'(bus.chg_valid), 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.chg_valid), 0);
    check("arst_denom", 32'(bus.chg_denom), 0);
    check("arst_state", 32'(bus.state_o), 0);
    check("arst_paid", 32'(bus.paid_o), 0);
    check("arst_due", 32'(bus.due_o), 0);
    check("arst_lines", 32'(bus.lines_o), 0);
    cyc();
    sys_rst_n = 1'b1;
    bus.chg_ready = 1'b1;
    repeat (3) cyc();
    check("postrst_valid", 32'(bus.chg_valid), 0);
    check("postrst_state", 32'(bus.state_o), 0);
    bus.chg_ready = 1'b0;

    // PAYMENT inactivity
    order(4'd4, 2'd1);
    step(0, 0, 0, 0, C10);
`ifdef VEND_TIMEOUT_EN
    repeat (15) cyc();
    check("tmo_before", 32'(bus.state_o), 2);
    cyc();
    check("tmo_state", 32'(bus.state_o), 4);
    check("tmo_denom", 32'(bus.chg_denom), 32'(C10));
    check("tmo_paid", 32'(bus.paid_o), 10);
    drain("tmo_drain", 10);
`else
    repeat (100) cyc();
    check("notmo_state", 32'(bus.state_o), 2);
    check("notmo_paid", 32'(bus.paid_o), 10);
    step(0, 0, 0, 1, 0);
    drain("notmo_drain", 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
